// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl: round-robin write arbiter and burst read sequencer for one shared FIFO
// Ports: clk, rst_n (async active-low); enable; req_valid/req_data/req_ready (producers);
//   fifo_enable, fifo_wf_en, fifo_rd_en, fifo_data_in, fifo_data_out (FIFO side);
//   out_ready, out_valid, out_data (consumer); burst_start, burst_done, level (status).
// Optional: define FIFO_CTRL_TIMEOUT_EN to drain partial data after TIMEOUT idle cycles.
module fifo_rr_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_enable,
  output logic                          fifo_wf_en,
  output logic                          fifo_rd_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          burst_start,
  output logic                          burst_done,
  output logic [$clog2(DEPTH):0]        level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LW-1:0] beats, beats_nx, blen;
  logic [PW-1:0] rr_ptr, win, cand;
  logic found, room, xfer, rd_issue, start, tmo;
  logic [LW:0] level_eff;
  assign fifo_enable = enable;
  assign out_data = fifo_data_out;
  // a registered write not yet folded into level still occupies a slot
  assign level_eff = {1'b0, level} + (LW+1)'(fifo_wf_en);
  assign room = rst_n && enable && !rd_issue && level_eff < (LW+1)'(DEPTH);
  assign xfer = found && room;
  assign req_ready = xfer ? NUM_REQ'(1) << win : '0;
  always_comb begin
    found = 1'b0;
    win = rr_ptr;
    cand = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win = cand;
      end
    end
  end
  always_comb begin
    state_nx = state;
    beats_nx = beats;
    start = 1'b0;
    rd_issue = 1'b0;
    case (state)
      IDLE: if (enable && (level >= LW'(BURST_LEN) || tmo)) begin
        state_nx = DRAIN;
        beats_nx = '0;
        start = 1'b1;
      end
      DRAIN: begin
        rd_issue = enable && out_ready && beats < blen;
        if (rd_issue) begin
          beats_nx = beats + 1'b1;
          if (beats + 1'b1 == blen) state_nx = DONE;
        end
      end
      // the last read is already registered, so it completes even with enable low
      DONE: if (fifo_rd_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beats <= '0;
      rr_ptr <= '0;
      level <= '0;
      fifo_wf_en <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_data_in <= '0;
      out_valid <= 1'b0;
      burst_start <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state <= state_nx;
      beats <= beats_nx;
      level <= level + LW'(fifo_wf_en) - LW'(fifo_rd_en);
      fifo_wf_en <= xfer;
      fifo_rd_en <= rd_issue;
      out_valid <= fifo_rd_en;
      burst_start <= start;
      burst_done <= state == DONE && fifo_rd_en;
      if (xfer) begin
        fifo_data_in <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr <= int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
      end
    end
  end
`ifdef FIFO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic idle_ok;
  assign idle_ok = state == IDLE && enable && level != '0 && level < LW'(BURST_LEN) && !fifo_wf_en && !xfer;
  assign tmo = idle_ok && idle_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      blen <= LW'(BURST_LEN);
    end else begin
      if (enable) idle_cnt <= idle_ok && !tmo ? idle_cnt + 1'b1 : '0;
      if (start) blen <= tmo ? level : LW'(BURST_LEN);
    end
  end
`else
  assign tmo = 1'b0;
  assign blen = LW'(BURST_LEN);
`endif
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb_fifo_rr_ctrl: self-checking bench for fifo_rr_ctrl with a behavioural FIFO and scoreboard
module tb_fifo_rr_ctrl;
  localparam int NR = 4, DW = 8, DEPTH = 128, BL = 16, TO = 64, LW = 8;
  typedef struct packed {logic [NR-1:0] v; logic [NR-1:0] r;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*DW-1:0] req_data = '0;
  logic fifo_enable, fifo_wf_en, fifo_rd_en, out_valid, burst_start, burst_done;
  logic [DW-1:0] fifo_data_in, fifo_data_out, out_data;
  logic [LW-1:0] level;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  fifo_rr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_enable(fifo_enable), .fifo_wf_en(fifo_wf_en), .fifo_rd_en(fifo_rd_en),
    .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .burst_start(burst_start), .burst_done(burst_done),
    .level(level)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural FIFO with one-cycle read latency
  logic [DW-1:0] mem[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.delete();
      fifo_data_out <= '0;
    end else begin
      if (fifo_rd_en && mem.size() > 0) fifo_data_out <= mem.pop_front();
      if (fifo_wf_en) mem.push_back(fifo_data_in);
    end
  end
  function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int rr);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (rr + i) % NR;
      if (v[k]) return NR'(1) << k;
    end
    return '0;
  endfunction
  // scoreboard: accepted words in order, occupancy from strobes, rr pointer from grant rule
  logic [DW-1:0] sb[$];
  logic [DW-1:0] p_word;
  int m_level, m_rr, wr_tot, rd_tot, ov_tot, bs_tot, bd_tot, bcnt, blen_exp;
  bit p_wr, p_rd, p_rdy, p_must;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_level = 0; m_rr = 0; p_wr = 0; p_rd = 0; p_rdy = 0; p_must = 0; bcnt = 0;
    end else begin
      int lvl_eff, idx;
      chk("excl", fifo_wf_en & fifo_rd_en, 0);
      chk("wr_strobe", fifo_wf_en, p_wr);
      if (p_wr && fifo_wf_en) chk("wr_data", fifo_data_in, p_word);
      chk("out_valid", out_valid, p_rd);
      if (p_must) chk("rd_when_blocked", fifo_rd_en, 1);
      if (fifo_rd_en) chk("rd_needs_ready", p_rdy, 1);
      chk("level", level, m_level);
      chk("level_max", level <= DEPTH, 1);
      chk("fifo_enable", fifo_enable, enable);
      if (burst_start) begin
        bcnt = 0;
        blen_exp = m_level >= BL ? BL : m_level;
        bs_tot++;
      end
      if (out_valid) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("out_data", out_data, sb.pop_front());
        ov_tot++;
        bcnt++;
      end
      if (burst_done) begin
        chk("done_with_valid", out_valid, 1);
        chk("burst_len", bcnt, blen_exp);
        bd_tot++;
      end
      lvl_eff = m_level + int'(fifo_wf_en);
      wr_tot += int'(fifo_wf_en);
      rd_tot += int'(fifo_rd_en);
      m_level = lvl_eff - int'(fifo_rd_en);
      p_must = req_ready == '0 && req_valid != '0 && enable && lvl_eff < DEPTH;
      p_wr = 0;
      if (req_ready != '0) begin
        chk("grant", req_ready, rr_pick(req_valid, m_rr));
        chk("grant_enable", enable, 1);
        chk("grant_room", lvl_eff < DEPTH, 1);
        idx = 0;
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) idx = i;
        m_rr = (idx + 1) % NR;
        p_wr = 1;
        p_word = req_data[idx*DW +: DW];
        sb.push_back(p_word);
      end
      p_rd = fifo_rd_en;
      p_rdy = out_ready;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic push_n(input int p, input int n);
    int k, g;
    k = 0; g = 0;
    req_valid = '0;
    req_valid[p] = 1'b1;
    req_data[p*DW +: DW] = DW'($urandom);
    while (k < n && g < 2000) begin
      #1;
      if (req_ready[p]) k++;
      @(posedge clk);
      #2;
      g++;
      req_data[p*DW +: DW] = DW'($urandom);
    end
    req_valid = '0;
    chk("push_done", k, n);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[12];
    int bs0, bd0, rd0, ov0, n;
    tbl = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
            '{4'b1010, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000},
            '{4'b0001, 4'b0001}, '{4'b1100, 4'b0100}, '{4'b0110, 4'b0010}, '{4'b0100, 4'b0100}};
    enable = 1'b1;
    req_valid = '1;
    tick(2);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_wf", fifo_wf_en, 0);
    chk("rst_rd", fifo_rd_en, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_bs", burst_start, 0);
    chk("rst_bd", burst_done, 0);
    chk("rst_din", fifo_data_in, 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].v;
      for (int p = 0; p < NR; p++) req_data[p*DW +: DW] = DW'(i * 16 + p);
      #1;
      chk("tbl_ready", req_ready, tbl[i].r);
      tick(1);
    end
    req_valid = '0;
    tick(2);
    chk("tbl_level", level, 11);
    req_valid = '1;
    for (int i = 0; i < 150; i++) begin
      req_data = {$urandom};
      tick(1);
    end
    #1;
    chk("full_no_grant", req_ready, 0);
    chk("full_level", level, DEPTH);
    chk("full_writes", wr_tot, DEPTH);
    req_valid = '0;
    out_ready = 1'b1;
    bd0 = bd_tot;
    n = 0;
    while (!(level == 0 && bd_tot - bd0 == 8) && n < 400) begin
      tick(1);
      n++;
    end
    chk("drain_bursts", bd_tot - bd0, 8);
    chk("drain_level", level, 0);
    bs0 = bs_tot; bd0 = bd_tot; rd0 = rd_tot; ov0 = ov_tot;
    push_n(2, BL);
    n = 0;
    while (bd_tot == bd0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("b16_start", bs_tot - bs0, 1);
    chk("b16_done", bd_tot - bd0, 1);
    chk("b16_reads", rd_tot - rd0, BL);
    chk("b16_words", ov_tot - ov0, BL);
    chk("b16_level", level, 0);
    out_ready = 1'b0;
    bd0 = bd_tot; rd0 = rd_tot; ov0 = ov_tot;
    push_n(1, BL);
    n = 0;
    while (bd_tot == bd0 && n < 200) begin
      out_ready = ~out_ready;
      tick(1);
      n++;
    end
    tick(2);
    chk("tog_done", bd_tot - bd0, 1);
    chk("tog_reads", rd_tot - rd0, BL);
    chk("tog_words", ov_tot - ov0, BL);
    chk("tog_level", level, 0);
    for (int i = 0; i < 1500; i++) begin
      req_valid = NR'($urandom);
      req_data = {$urandom};
      out_ready = ($urandom % 4) != 0;
      enable = ($urandom % 8) != 0;
      tick(1);
    end
    req_valid = '0;
    enable = 1'b1;
    out_ready = 1'b1;
    tick(400);
    chk("rand_partial", level < BL, 1);
    chk("rand_sb_level", level, sb.size());
    chk("rand_balance", level, wr_tot - rd_tot);
`ifdef FIFO_CTRL_TIMEOUT_EN
    chk("tmo_pre_level", level, 0);
    bs0 = bs_tot; bd0 = bd_tot; ov0 = ov_tot;
    push_n(3, 3);
    n = 0;
    while (bs_tot == bs0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("tmo_delay_min", n >= TO, 1);
    chk("tmo_delay_max", n <= TO + 4, 1);
    n = 0;
    while (bd_tot == bd0 && n < 50) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("tmo_words", ov_tot - ov0, 3);
    chk("tmo_level", level, 0);
`endif
    out_ready = 1'b1;
    push_n(0, BL);
    tick(5);
    chk("pre_rst_busy", level != 0, 1);
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_wf", fifo_wf_en, 0);
    chk("mid_rst_rd", fifo_rd_en, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_bs", burst_start, 0);
    chk("mid_rst_bd", burst_done, 0);
    tick(1);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    tick(1);
    req_valid = '0;
    tick(2);
    chk("post_rst_level", level, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
